// File: rtl/arch_defs_pkg.sv
// Shared architectural definitions for the datapath core: command modes,
// ALU opcodes and the layout of the condition-flag vector.
package arch_defs_pkg;

    typedef enum logic [2:0] {
        MOV   = 3'd0,
        ALU   = 3'd1,
        LDI   = 3'd2,
        LOAD  = 3'd3,
        STORE = 3'd4
    } dp_mode_t;

    typedef enum logic [2:0] {
        ADD  = 3'd0,
        SUB  = 3'd1,
        AND  = 3'd2,
        OR   = 3'd3,
        XOR  = 3'd4,
        INC  = 3'd5,
        DEC  = 3'd6,
        PASS = 3'd7
    } dp_alu_op_t;

    // Flag vector is {V,N,C,Z}, Z in bit 0.
    localparam int FLAG_COUNT = 4;
    localparam int FLAG_Z     = 0;
    localparam int FLAG_C     = 1;
    localparam int FLAG_N     = 2;
    localparam int FLAG_V     = 3;

    function automatic logic [FLAG_COUNT-1:0] pack_flags(input logic v, input logic n,
                                                         input logic c, input logic z);
        logic [FLAG_COUNT-1:0] f;
        f         = '0;
        f[FLAG_V] = v;
        f[FLAG_N] = n;
        f[FLAG_C] = c;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_nbit.sv
// Combinational N-bit ALU returning a wrapped result and {V,N,C,Z} flags.
// INC/DEC substitute a constant 1 for operand b; PASS forwards operand a.
module alu_nbit
    import arch_defs_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  dp_alu_op_t              op,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic [DATA_WIDTH-1:0]   result,
    output logic [FLAG_COUNT-1:0]   flags
);

    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH-1:0] operand;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   diff;
    logic                  carry;
    logic                  ovf;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        operand = (op == INC || op == DEC) ? DATA_WIDTH'(1) : b;
        sum     = {1'b0, a} + {1'b0, operand};
        diff    = {1'b0, a} - {1'b0, operand};
        result  = a;
        carry   = 1'b0;
        ovf     = 1'b0;
        case (op)
            ADD, INC: begin
                result = sum[MSB:0];
                carry  = sum[DATA_WIDTH];
                ovf    = (a[MSB] == operand[MSB]) && (result[MSB] != a[MSB]);
            end
            SUB, DEC: begin
                // The extra MSB of the widened difference is the unsigned borrow.
                result = diff[MSB:0];
                carry  = diff[DATA_WIDTH];
                ovf    = (a[MSB] != operand[MSB]) && (result[MSB] != a[MSB]);
            end
            AND:     result = a & b;
            OR:      result = a | b;
            XOR:     result = a ^ b;
            default: result = a;
        endcase
        flags = pack_flags(ovf, result[MSB], carry, result == '0);
    end

endmodule

// File: rtl/datapath_core.sv
// Register-file datapath: single-cycle MOV/ALU/LDI plus LOAD/STORE over a
// req/ack memory port with a bounded wait and a sticky timeout error.
module datapath_core
    import arch_defs_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int NUM_REGS    = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  dp_mode_t                    cmd_mode,
    input  dp_alu_op_t                  cmd_alu_op,
    input  logic [$clog2(NUM_REGS)-1:0] cmd_dst,
    input  logic [$clog2(NUM_REGS)-1:0] cmd_src,
    input  logic [DATA_WIDTH-1:0]       cmd_imm,
    input  logic [ADDR_WIDTH-1:0]       cmd_addr,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [DATA_WIDTH-1:0]       mem_wdata,
    input  logic [DATA_WIDTH-1:0]       mem_rdata,
    input  logic                        mem_ack,
    output logic [FLAG_COUNT-1:0]       flags_o,
    output logic                        mem_err_o,
    input  logic [$clog2(NUM_REGS)-1:0] dbg_sel,
    output logic [DATA_WIDTH-1:0]       dbg_data
);

    localparam int REG_W = $clog2(NUM_REGS);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int MSB   = DATA_WIDTH - 1;

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

    logic [0:0]            state;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [FLAG_COUNT-1:0] flags;
    logic                  mem_err;
    logic [CNT_W-1:0]      wait_cnt;
    dp_mode_t              lat_mode;
    logic [REG_W-1:0]      lat_dst;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;

    logic [DATA_WIDTH-1:0] alu_result;
    logic [FLAG_COUNT-1:0] alu_flags;
    logic                  accept;

    alu_nbit #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .op     (cmd_alu_op),
        .a      (regs[cmd_dst]),
        .b      (regs[cmd_src]),
        .result (alu_result),
        .flags  (alu_flags)
    );

    assign accept    = cmd_valid && cmd_ready;
    assign cmd_ready = (state == IDLE);
    assign mem_req   = (state == MEM_WAIT);
    assign mem_we    = mem_req && (lat_mode == STORE);
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign flags_o   = flags;
    assign mem_err_o = mem_err;
    assign dbg_data  = regs[dbg_sel];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            flags     <= '0;
            mem_err   <= 1'b0;
            wait_cnt  <= '0;
            lat_mode  <= MOV;
            lat_dst   <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            // NOTE: the register file is built from flops, not RAM, because every entry must clear on reset.
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            // NOTE: state uses <= only, so every read in this block and dbg_data see pre-edge values.
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (cmd_mode)
                            MOV: regs[cmd_dst] <= regs[cmd_src];
                            ALU: begin
                                regs[cmd_dst] <= alu_result;
                                flags         <= alu_flags;
                            end
                            LDI: begin
                                regs[cmd_dst] <= cmd_imm;
                                flags         <= pack_flags(1'b0, cmd_imm[MSB], 1'b0, cmd_imm == '0);
                            end
                            LOAD, STORE: begin
                                lat_mode  <= cmd_mode;
                                lat_dst   <= cmd_dst;
                                lat_addr  <= cmd_addr;
                                lat_wdata <= regs[cmd_src];
                                wait_cnt  <= '0;
                                state     <= MEM_WAIT;
                            end
                            default: ;
                        endcase
                    end
                end
                default: begin
                    // Ack is tested first so it wins over a timeout expiring on the same edge.
                    if (mem_ack) begin
                        state <= IDLE;
                        if (lat_mode == LOAD) begin
                            regs[lat_dst] <= mem_rdata;
                            flags         <= pack_flags(1'b0, mem_rdata[MSB], 1'b0, mem_rdata == '0);
                        end
                    end else if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                        state   <= IDLE;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_core.sv
// Scoreboard bench for datapath_core: stimulus queues expected register probes
// and memory transactions; independent monitors pop and compare them.
module tb_datapath_core;
    import arch_defs_pkg::*;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int NR = 4;
    localparam int TO = 15;

    logic             clk;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    dp_mode_t         cmd_mode;
    dp_alu_op_t       cmd_alu_op;
    logic [1:0]       cmd_dst;
    logic [1:0]       cmd_src;
    logic [DW-1:0]    cmd_imm;
    logic [AW-1:0]    cmd_addr;
    logic             mem_req;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata;
    logic             mem_ack;
    logic [3:0]       flags_o;
    logic             mem_err_o;
    logic [1:0]       dbg_sel;
    logic [DW-1:0]    dbg_data;

    datapath_core #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REGS   (NR),
        .MEM_TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_alu_op(cmd_alu_op),
        .cmd_dst   (cmd_dst),
        .cmd_src   (cmd_src),
        .cmd_imm   (cmd_imm),
        .cmd_addr  (cmd_addr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .flags_o   (flags_o),
        .mem_err_o (mem_err_o),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] sel;
        logic [7:0] data;
        logic [3:0] flags;
        logic       err;
        logic       ready;
    } probe_t;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       chk_wdata;
        int         len;
    } mem_t;

    probe_t probe_q[$];
    mem_t   mem_q[$];
    int     n_cmp = 0;
    int     n_err = 0;
    logic   probe_req = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Register/flag monitor: compares whenever stimulus raises a probe.
    always @(negedge clk) begin
        if (probe_req) begin
            check("probe_q_nonempty", probe_q.size() != 0, 1);
            if (probe_q.size() != 0) begin
                probe_t p;
                p = probe_q.pop_front();
                check({p.name, "_data"},  dbg_data,  p.data);
                check({p.name, "_flags"}, flags_o,   p.flags);
                check({p.name, "_err"},   mem_err_o, p.err);
                check({p.name, "_ready"}, cmd_ready, p.ready);
            end
        end
    end

    // Memory monitor: one expected transaction per mem_req burst.
    int   mcnt = 0;
    mem_t cur;
    always @(negedge clk) begin
        if (mem_req) begin
            if (mcnt == 0) begin
                check("mem_req_expected", mem_q.size() != 0, 1);
                if (mem_q.size() != 0) cur = mem_q.pop_front();
                check("ready_low_in_wait", cmd_ready, 0);
            end
            check("mem_we", mem_we, cur.we);
            check("mem_addr", mem_addr, cur.addr);
            if (cur.chk_wdata) check("mem_wdata", mem_wdata, cur.wdata);
            mcnt++;
        end else if (mcnt > 0) begin
            check("mem_wait_cycles", mcnt, cur.len);
            mcnt = 0;
        end
    end

    task automatic wait_ready(input int budget);
        for (int i = 0; i < budget && !cmd_ready; i++) begin
            @(posedge clk);
            #1;
        end
        check("cmd_ready_wait", cmd_ready, 1);
    endtask

    task automatic drive(input dp_mode_t m, input dp_alu_op_t op, input logic [1:0] d,
                         input logic [1:0] s, input logic [7:0] imm, input logic [7:0] addr);
        cmd_mode   = m;
        cmd_alu_op = op;
        cmd_dst    = d;
        cmd_src    = s;
        cmd_imm    = imm;
        cmd_addr   = addr;
        cmd_valid  = 1'b1;
    endtask

    // Called and returns at posedge+1; consecutive calls give back-to-back accepts.
    task automatic issue(input dp_mode_t m, input dp_alu_op_t op, input logic [1:0] d,
                         input logic [1:0] s, input logic [7:0] imm, input logic [7:0] addr);
        wait_ready(40);
        drive(m, op, d, s, imm, addr);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic probe(input string name, input logic [1:0] sel, input logic [7:0] data,
                         input logic [3:0] flags, input logic err, input logic ready);
        dbg_sel = sel;
        probe_q.push_back('{name, sel, data, flags, err, ready});
        probe_req = 1'b1;
        @(negedge clk);
        #1 probe_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Ack sampled on the n-th edge after the accepting edge (n-th MEM_WAIT cycle).
    task automatic ack_on(input int n, input logic [7:0] rd);
        repeat (n - 1) @(posedge clk);
        #1;
        mem_ack   = 1'b1;
        mem_rdata = rd;
        @(posedge clk);
        #1 mem_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_mode   = MOV;
        cmd_alu_op = PASS;
        cmd_dst    = '0;
        cmd_src    = '0;
        cmd_imm    = '0;
        cmd_addr   = '0;
        mem_rdata  = '0;
        mem_ack    = 1'b0;
        dbg_sel    = '0;

        repeat (2) @(posedge clk);
        #1;
        probe("rst_r0", 2'd0, 8'h00, 4'b0000, 1'b0, 1'b1);
        probe("rst_r3", 2'd3, 8'h00, 4'b0000, 1'b0, 1'b1);
        reset = 1'b1;

        // Signed overflow on ADD: 0x7F + 0x01, first accept right after reset.
        issue(LDI, PASS, 2'd0, 2'd0, 8'h7F, 8'h00);
        issue(LDI, PASS, 2'd1, 2'd0, 8'h01, 8'h00);
        issue(ALU, ADD,  2'd0, 2'd1, 8'h00, 8'h00);
        probe("add_ovf", 2'd0, 8'h80, 4'b1100, 1'b0, 1'b1);

        issue(LDI, PASS, 2'd2, 2'd0, 8'h00, 8'h00);
        probe("ldi_zero", 2'd2, 8'h00, 4'b0001, 1'b0, 1'b1);
        issue(ALU, DEC, 2'd2, 2'd0, 8'h00, 8'h00);
        probe("dec_wrap", 2'd2, 8'hFF, 4'b0110, 1'b0, 1'b1);
        issue(MOV, PASS, 2'd3, 2'd2, 8'h00, 8'h00);
        probe("mov", 2'd3, 8'hFF, 4'b0110, 1'b0, 1'b1);

        // STORE R3 -> 0x40, ack in the third wait cycle.
        mem_q.push_back('{1'b1, 8'h40, 8'hFF, 1'b1, 3});
        issue(STORE, PASS, 2'd0, 2'd3, 8'h00, 8'h40);
        ack_on(3, 8'h00);
        probe("store_done", 2'd3, 8'hFF, 4'b0110, 1'b0, 1'b1);

        // LOAD R1 with no ack: timeout after 15 cycles, R1 and flags untouched.
        mem_q.push_back('{1'b0, 8'h40, 8'h00, 1'b0, TO});
        issue(LOAD, PASS, 2'd1, 2'd0, 8'h00, 8'h40);
        wait_ready(40);
        probe("load_timeout", 2'd1, 8'h01, 4'b0110, 1'b1, 1'b1);

        // Reset in the middle of MEM_WAIT.
        mem_q.push_back('{1'b0, 8'h10, 8'h00, 1'b0, 1});
        issue(LOAD, PASS, 2'd2, 2'd0, 8'h00, 8'h10);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("mem_req_async_drop", mem_req, 0);
        check("mem_we_async_drop", mem_we, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        for (int r = 0; r < NR; r++)
            probe($sformatf("post_rst_r%0d", r), 2'(r), 8'h00, 4'b0000, 1'b0, 1'b1);

        // LOAD acked on exactly the 15th wait cycle completes normally.
        mem_q.push_back('{1'b0, 8'h22, 8'h00, 1'b0, TO});
        issue(LOAD, PASS, 2'd0, 2'd0, 8'h00, 8'h22);
        ack_on(TO, 8'h80);
        probe("load_ack15", 2'd0, 8'h80, 4'b0100, 1'b0, 1'b1);

        // Stray ack while IDLE must not write anything.
        mem_ack   = 1'b1;
        mem_rdata = 8'h33;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        probe("stray_ack", 2'd0, 8'h80, 4'b0100, 1'b0, 1'b1);

        // Carry + overflow, subtraction, logic op.
        issue(LDI, PASS, 2'd1, 2'd0, 8'h90, 8'h00);
        issue(ALU, ADD,  2'd0, 2'd1, 8'h00, 8'h00);
        probe("add_carry", 2'd0, 8'h10, 4'b1010, 1'b0, 1'b1);
        issue(ALU, SUB, 2'd1, 2'd0, 8'h00, 8'h00);
        probe("sub", 2'd1, 8'h80, 4'b0100, 1'b0, 1'b1);
        issue(ALU, XOR, 2'd1, 2'd1, 8'h00, 8'h00);
        probe("xor_zero", 2'd1, 8'h00, 4'b0001, 1'b0, 1'b1);

        // dbg_data shows the pre-edge value of a register being written.
        dbg_sel = 2'd2;
        probe_q.push_back('{"dbg_pre_edge", 2'd2, 8'h00, 4'b0001, 1'b0, 1'b1});
        drive(LDI, PASS, 2'd2, 2'd0, 8'hA5, 8'h00);
        probe_req = 1'b1;
        @(negedge clk);
        #1 probe_req = 1'b0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        probe("ldi_post", 2'd2, 8'hA5, 4'b0100, 1'b0, 1'b1);

        repeat (2) @(posedge clk);
        check("probe_q_drained", probe_q.size(), 0);
        check("mem_q_drained", mem_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/datapath_core.md
DATAPATH_CORE -- requirements
Module: datapath_core

Interface
REQ-001 The module SHALL declare parameter DATA_WIDTH, default 8, as the register, ALU and memory data width (>=4).
REQ-002 The module SHALL declare parameter ADDR_WIDTH, default 8, as the memory address width.
REQ-003 The module SHALL declare parameter NUM_REGS, default 4, as the register-file depth (power of two, >=2).
REQ-004 The module SHALL declare parameter MEM_TIMEOUT, default 15, as the maximum wait cycles for mem_ack (>=1).
REQ-005 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port reset, input, 1, an asynchronous active-low reset (asserted at 0).
REQ-007 The module SHALL have port cmd_valid, input, 1, command present.
REQ-008 The module SHALL have port cmd_ready, output, 1, command accepted this cycle when high with cmd_valid.
REQ-009 The module SHALL have port cmd_mode, input, dp_mode_t, one of MOV, ALU, LDI, LOAD, STORE.
REQ-010 The module SHALL have port cmd_alu_op, input, dp_alu_op_t, one of ADD, SUB, AND, OR, XOR, INC, DEC, PASS.
REQ-011 The module SHALL have ports cmd_dst and cmd_src, input, $clog2(NUM_REGS) each, register indices.
REQ-012 The module SHALL have port cmd_imm, input, DATA_WIDTH, the LDI immediate.
REQ-013 The module SHALL have port cmd_addr, input, ADDR_WIDTH, the LOAD/STORE address.
REQ-014 The module SHALL have ports mem_req, mem_we (output, 1), mem_addr (output, ADDR_WIDTH), mem_wdata (output, DATA_WIDTH), mem_rdata (input, DATA_WIDTH) and mem_ack (input, 1).
REQ-015 The module SHALL have port flags_o, output, FLAG_COUNT=4, {V,N,C,Z} with Z at bit 0.
REQ-016 The module SHALL have port mem_err_o, output, 1, sticky memory-timeout error.
REQ-017 The module SHALL have ports dbg_sel (input, $clog2(NUM_REGS)) and dbg_data (output, DATA_WIDTH), a combinational register read.

Function
REQ-018 The FSM SHALL have states IDLE and MEM_WAIT; cmd_ready SHALL be 1 exactly in IDLE.
REQ-019 MOV, ALU and LDI SHALL complete at the accepting edge: R[dst] updated, FSM stays IDLE, back-to-back accepts allowed every cycle.
REQ-020 MOV SHALL write R[src] to R[dst], leaving flags unchanged.
REQ-021 ALU SHALL write R[dst] op R[src] to R[dst]; INC/DEC/PASS SHALL use R[dst] only; results SHALL wrap modulo 2^DATA_WIDTH.
REQ-022 ALU flags SHALL be: Z=result zero; N=result MSB; C=carry-out for ADD/INC, borrow (A<B unsigned) for SUB/DEC, 0 for logic/PASS; V=signed overflow for ADD/SUB/INC/DEC, 0 otherwise.
REQ-023 LDI SHALL write cmd_imm to R[dst] and set Z,N from cmd_imm with C=V=0.
REQ-024 LOAD/STORE acceptance SHALL latch mode, dst, addr and (STORE) R[src] and enter MEM_WAIT.
REQ-025 In MEM_WAIT mem_req SHALL be 1, mem_we SHALL be 1 for STORE only, and mem_addr/mem_wdata SHALL hold the latched values stable.
REQ-026 On mem_ack in MEM_WAIT the FSM SHALL return to IDLE; LOAD SHALL write mem_rdata to R[dst] and set Z,N with C=V=0; STORE SHALL leave flags unchanged.
REQ-027 A wait counter SHALL count MEM_WAIT cycles without ack; after MEM_TIMEOUT such cycles the FSM SHALL return to IDLE, set mem_err_o, and write no register or flag.
REQ-028 mem_ack in the same cycle as timeout expiry SHALL complete normally (ack wins, no error).
REQ-029 mem_ack outside MEM_WAIT SHALL be ignored.
REQ-030 mem_err_o SHALL remain set until reset.
REQ-031 dbg_data SHALL show the pre-edge register value when dbg_sel equals a register written that cycle.

Reset
REQ-032 Reset assertion SHALL immediately force IDLE, all registers, flags_o, mem_err_o, the wait counter, mem_req and mem_we to 0, including mid-MEM_WAIT.
REQ-033 The first command SHALL be acceptable in the first cycle after reset deasserts.

Structure
REQ-034 dp_mode_t, dp_alu_op_t, FLAG_COUNT and flag bit indices SHALL live in arch_defs_pkg.
REQ-035 The ALU SHALL be a combinational sub-module alu_nbit, parametrised by DATA_WIDTH, returning result and four flags.

Verification
REQ-036 LDI R0,0x7F; LDI R1,0x01; ALU ADD R0,R1 -> R0=0x80, flags N=1 V=1 C=0 Z=0.
REQ-037 LDI R2,0x00; ALU DEC R2 -> R2=0xFF, C=1 N=1 Z=0 V=0; then MOV R3,R2 -> R3=0xFF, flags unchanged.
REQ-038 STORE R3 to 0x40, ack after 3 cycles -> mem_we=1, mem_wdata=0xFF held, cmd_ready low 3 cycles, IDLE after ack.
REQ-039 LOAD R1 from 0x40 with mem_ack never asserted -> return to IDLE after 15 cycles, mem_err_o=1, R1 unchanged.
REQ-040 Assert reset during MEM_WAIT -> mem_req drops same cycle, all registers 0, cmd_ready=1 after release.
REQ-041 LOAD with ack on cycle 15 exactly -> R[dst]=mem_rdata, mem_err_o=0.
